// File: rtl/data_mem_responder.sv
// Word-addressed data memory: single reads/writes and aligned 8-word burst reads, fixed LATENCY response pipe.
// Read data appears LATENCY cycles after acceptance; req_ready drops only while a burst issues, responses cannot be stalled.
module data_mem_responder #(
  parameter int DWIDTH     = 16,
  parameter int AWIDTH     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4,
  parameter int BURST_LEN  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic              req_burst,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_data,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_data,
  output logic [2:0]        rsp_idx,
  output logic              rsp_last
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;
  localparam logic [2:0] LAST_IDX = 3'(BURST_LEN - 1);

  typedef struct packed {
    logic              vld;
    logic [DWIDTH-1:0] dat;
    logic [2:0]        idx;
    logic              last;
  } stage_t;

  logic [DWIDTH-1:0]     mem_q [DEPTH];
  logic [0:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] bbase_q, bbase_d;
  logic [2:0]            bcnt_q, bcnt_d;
  stage_t [LATENCY-1:0]  pipe_q, pipe_d;
  stage_t                iss;
  logic                  accept;
  logic [DEPTH_LOG2-1:0] req_word, rd_word;
  logic                  unused_addr_bits;

  // Gating with rst keeps the port closed for every cycle reset is held.
  assign req_ready        = (state_q == ST_IDLE) && !rst;
  assign accept           = req_valid && req_ready;
  assign req_word         = req_addr[DEPTH_LOG2:1];
  assign unused_addr_bits = ^{req_addr[AWIDTH-1:DEPTH_LOG2+1], req_addr[0]};

  always_comb begin
    state_d = state_q;
    bbase_d = bbase_q;
    bcnt_d  = bcnt_q;
    rd_word = req_word;
    iss     = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept && !req_wr) begin
          iss.vld = 1'b1;
          if (req_burst) begin
            rd_word = {req_word[DEPTH_LOG2-1:3], 3'b000};
            bbase_d = rd_word;
            bcnt_d  = 3'd1;
            state_d = ST_BURST;
          end else begin
            iss.last = 1'b1;
          end
        end
      end
      default: begin
        iss.vld  = 1'b1;
        rd_word  = bbase_q | {{(DEPTH_LOG2-3){1'b0}}, bcnt_q};
        iss.idx  = bcnt_q;
        iss.last = (bcnt_q == LAST_IDX);
        bcnt_d   = bcnt_q + 3'd1;
        if (iss.last) state_d = ST_IDLE;
      end
    endcase
    // Idle slots carry zero data so the outputs read 0 whenever rsp_valid is low.
    if (iss.vld) iss.dat = mem_q[rd_word];
  end

  always_comb begin
    pipe_d = pipe_q;
    for (int i = LATENCY - 1; i > 0; i--) pipe_d[i] = pipe_q[i-1];
    pipe_d[0] = iss;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bbase_q <= '0;
      bcnt_q  <= '0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      bbase_q <= bbase_d;
      bcnt_q  <= bcnt_d;
      pipe_q  <= pipe_d;
    end
  end

  // Storage is deliberately outside reset; writes cannot occur during rst since req_ready is low.
  always_ff @(posedge clk) begin
    if (accept && req_wr) mem_q[req_word] <= req_data;
  end

  assign rsp_valid = pipe_q[LATENCY-1].vld;
  assign rsp_data  = pipe_q[LATENCY-1].dat;
  assign rsp_idx   = pipe_q[LATENCY-1].idx;
  assign rsp_last  = pipe_q[LATENCY-1].last;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: two responders (LATENCY 4 and 1) share one stimulus stream; a negedge monitor checks each.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic        req_burst = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_data = '0;

  logic        rdy4, vld4, last4;
  logic [15:0] dat4;
  logic [2:0]  idx4;
  logic        rdy1, vld1, last1;
  logic [15:0] dat1;
  logic [2:0]  idx1;

  typedef struct {
    int          cyc;
    logic [15:0] dat;
    logic [2:0]  idx;
    logic        last;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   armed = 1'b0;

  data_mem_responder #(.LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy4),
    .req_wr(req_wr), .req_burst(req_burst), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(vld4), .rsp_data(dat4), .rsp_idx(idx4), .rsp_last(last4)
  );

  data_mem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
    .req_wr(req_wr), .req_burst(req_burst), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(vld1), .rsp_data(dat1), .rsp_idx(idx1), .rsp_last(last1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic mon(input int which, input logic vld, input logic [15:0] dat,
                     input logic [2:0] idx, input logic last);
    exp_t e;
    int   n;
    n = (which == 4) ? q4.size() : q1.size();
    if (vld) begin
      checks++;
      if (n == 0) begin
        errors++;
        $display("FAIL rsp_lat%0d_unexpected: got data 0x%h idx %0d at cycle %0d, expected no response",
                 which, dat, idx, cyc);
      end else begin
        e = (which == 4) ? q4.pop_front() : q1.pop_front();
        if (e.cyc != cyc || e.dat !== dat || e.idx !== idx || e.last !== last) begin
          errors++;
          $display("FAIL rsp_lat%0d: got cyc %0d dat 0x%h idx %0d last %0b, expected cyc %0d dat 0x%h idx %0d last %0b",
                   which, cyc, dat, idx, last, e.cyc, e.dat, e.idx, e.last);
        end
      end
    end else begin
      chk($sformatf("idle_zero_lat%0d", which), {12'b0, dat, idx, last}, 32'h0);
      if (n > 0) begin
        e = (which == 4) ? q4[0] : q1[0];
        if (e.cyc <= cyc) begin
          checks++;
          errors++;
          $display("FAIL rsp_lat%0d_missing: got no response at cycle %0d, expected dat 0x%h idx %0d",
                   which, cyc, e.dat, e.idx);
          if (which == 4) void'(q4.pop_front()); else void'(q1.pop_front());
        end
      end
    end
  endtask

  // Expectations from before a reset are dropped: those responses must never appear.
  always @(negedge clk) begin
    if (rst) begin
      q4.delete();
      q1.delete();
    end else if (armed) begin
      mon(4, vld4, dat4, idx4, last4);
      mon(1, vld1, dat1, idx1, last1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] dat, input logic [2:0] idx, input logic last, input int off);
    exp_t e;
    e.dat = dat; e.idx = idx; e.last = last;
    e.cyc = cyc + off + 4;
    q4.push_back(e);
    e.cyc = cyc + off + 1;
    q1.push_back(e);
  endtask

  task automatic issue(input logic wr, input logic burst, input logic [15:0] addr, input logic [15:0] data);
    req_valid = 1'b1;
    req_wr    = wr;
    req_burst = burst;
    req_addr  = addr;
    req_data  = data;
    tick();
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_burst = 1'b0;
  endtask

  task automatic chk_ready(input logic exp, input string name);
    #2;
    chk({name, "_lat4"}, {31'b0, rdy4}, {31'b0, exp});
    chk({name, "_lat1"}, {31'b0, rdy1}, {31'b0, exp});
  endtask

  task automatic burst_expect(input logic [15:0] first, input logic [15:0] base_val);
    push(first, 3'd0, 1'b0, 0);
    for (int k = 1; k < 8; k++) push(base_val + 16'(k), 3'(k), k == 7, k);
  endtask

  initial begin
    // Power-up reset
    rst = 1'b1;
    repeat (3) begin
      tick();
      chk_ready(1'b0, "ready_in_reset");
    end
    tick();
    rst   = 1'b0;
    armed = 1'b1;
    chk_ready(1'b1, "ready_after_reset");
    chk("rsp_valid_after_reset", {30'b0, vld4, vld1}, 32'h0);
    chk("rsp_fields_after_reset", {dat4, idx4, last4, 12'b0}, 32'h0);
    tick();

    // Write then read, including the odd-byte alias of the same word
    issue(1'b1, 1'b0, 16'h0010, 16'hBEEF);
    push(16'hBEEF, 3'd0, 1'b1, 0);
    issue(1'b0, 1'b0, 16'h0010, 16'h0000);
    push(16'hBEEF, 3'd0, 1'b1, 0);
    issue(1'b0, 1'b0, 16'h0011, 16'h0000);
    repeat (6) tick();

    // Pipelined single reads
    for (int k = 0; k < 8; k++) issue(1'b1, 1'b0, 16'(2 * k), 16'h1000 + 16'(k));
    push(16'h1003, 3'd0, 1'b1, 0); issue(1'b0, 1'b0, 16'h0006, 16'h0);
    push(16'h1000, 3'd0, 1'b1, 0); issue(1'b0, 1'b0, 16'h0000, 16'h0);
    push(16'h1007, 3'd0, 1'b1, 0); issue(1'b0, 1'b0, 16'h000E, 16'h0);
    push(16'h1001, 3'd0, 1'b1, 0); issue(1'b0, 1'b0, 16'h0002, 16'h0);
    repeat (6) tick();

    // Burst read from a mid-line address, then a read accepted right as ready returns
    for (int k = 0; k < 8; k++) issue(1'b1, 1'b0, 16'h0030 + 16'(2 * k), 16'hA0A0 + 16'(k));
    burst_expect(16'hA0A0, 16'hA0A0);
    issue(1'b0, 1'b1, 16'h0036, 16'h0);
    for (int j = 1; j < 8; j++) begin
      chk_ready(1'b0, "ready_during_burst");
      tick();
    end
    chk_ready(1'b1, "ready_after_burst");
    push(16'hA0A0, 3'd0, 1'b1, 0);
    issue(1'b0, 1'b0, 16'h0030, 16'h0);
    repeat (12) tick();

    // Write carrying the burst flag acts as a single write
    for (int k = 0; k < 8; k++) issue(1'b1, 1'b0, 16'h0040 + 16'(2 * k), 16'h4000 + 16'(k));
    issue(1'b1, 1'b1, 16'h0040, 16'h5555);
    chk_ready(1'b1, "ready_after_wr_burst");
    burst_expect(16'h5555, 16'h4000);
    issue(1'b0, 1'b1, 16'h0048, 16'h0);
    repeat (14) tick();

    // Reset in cycle 3 of a burst
    burst_expect(16'hA0A0, 16'hA0A0);
    issue(1'b0, 1'b1, 16'h003A, 16'h0);
    tick();
    rst = 1'b1;
    chk_ready(1'b0, "ready_mid_burst_reset");
    tick();
    chk_ready(1'b0, "ready_mid_burst_reset2");
    tick();
    rst = 1'b0;
    chk_ready(1'b1, "ready_after_mid_reset");
    chk("rsp_valid_after_mid_reset", {30'b0, vld4, vld1}, 32'h0);
    repeat (10) tick();

    // Recovery: storage survives reset
    push(16'hBEEF, 3'd0, 1'b1, 0);
    issue(1'b0, 1'b0, 16'h0010, 16'h0);
    repeat (8) tick();

    chk("queue_drained_lat4", 32'(q4.size()), 32'h0);
    chk("queue_drained_lat1", 32'(q1.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
